wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter and destination scoreboard for the RV32IM core. It merges single-cycle ALU results and multi-cycle MUL/DIV results onto the register file's single write port (`rf_write_enable`/`rf_rdi`/`rf_rd`). A small FIFO buffers MUL/DIV results while the port is busy. It also tracks which architectural registers have a MUL/DIV result outstanding, so hazard logic can stall dependent instructions.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `FIFO_DEPTH`, 2, MUL/DIV result buffer entries (power of two, ≥1).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `alu_valid`  in  1  ALU result present this cycle; cannot be stalled.
- `alu_rd`  in  5  ALU destination index.
- `alu_data`  in  XLEN  ALU result.
- `md_valid`  in  1  MUL/DIV result offered.
- `md_ready`  out  1  arbiter accepts MUL/DIV result this cycle.
- `md_rd`  in  5  MUL/DIV destination index.
- `md_data`  in  XLEN  MUL/DIV result.
- `issue_valid`  in  1  MUL/DIV instruction issued this cycle.
- `issue_rd`  in  5  its destination index.
- `busy`  out  32  per-register outstanding-MUL/DIV flag; bit 0 constant 0.
- `rf_write_enable`  out  1  register file write strobe (registered).
- `rf_rdi`  out  5  write index (registered).
- `rf_rd`  out  XLEN  write data (registered).

## Operation
- ALU results have absolute priority.
  - If `alu_valid`, the output register loads `{alu_rd, alu_data}` next edge.
  - `rf_write_enable` is set only if `alu_rd != 0`.
- MUL/DIV handshake:
  - A transfer occurs when `md_valid && md_ready`.
  - `md_ready = !rst && !fifo_full`.
  - `md_valid` with its payload is held stable until accepted.
- When `alu_valid` is 0, the MUL/DIV source is selected as follows:
  - FIFO non-empty: pop the head into the output register.
  - FIFO empty and a MUL/DIV transfer occurs: bypass it directly into the output register; it is not enqueued.
- When `alu_valid` is 1, a transferred MUL/DIV result is enqueued.
- A simultaneous pop and push on a full FIFO is legal.
  - `md_ready` still reflects pre-edge fullness, so a push on full is never accepted.
- Output register with no selected source: `rf_write_enable <= 0`; `rf_rdi`/`rf_rd` hold their previous values.
- A MUL/DIV result with `rd == 0` is consumed normally and produces `rf_write_enable = 0`.
- Scoreboard:
  - `busy[issue_rd]` is set on `issue_valid && issue_rd != 0`.
  - `busy[rdi]` is cleared on the edge where a MUL/DIV entry is loaded into the output register.
  - Set and clear of the same index on the same edge: set wins.
  - Issuing to an already-busy register leaves it busy; the first write-back clears it. Upstream hazard logic prevents this case.
  - ALU writes never modify `busy`.
- Starvation: continuous `alu_valid` fills the FIFO and deasserts `md_ready`. This is accepted by design, because the decoder stalls issue while any `busy` bit blocks.

## Timing
- Reset values:
  - `rf_write_enable = 0`, `rf_rdi = 0`, `rf_rd = 0`.
  - `busy = 0`.
  - FIFO empty.
  - `md_ready = 0` while `rst` is high.
- Reset mid-operation discards FIFO contents and pending busy bits. Nothing is written after the reset edge.
- ALU latency: input cycle N → `rf_write_enable` high in cycle N+1. The register file commits at the end of N+1.
- MUL/DIV latency:
  - 1 cycle when bypassed.
  - Otherwise, 1 cycle after the last ALU cycle that blocked it, plus its FIFO position.
- `busy` is registered. A set from `issue_valid` in cycle N is visible in N+1. A clear is visible in the same cycle that `rf_write_enable` shows the MUL/DIV write.
- `md_ready` is combinational from FIFO state only. It never depends on `md_valid` or `alu_valid`.

## Structure
- Shared package `rv_pkg`:
  - `XLEN`
  - `REG_IDX_W = 5`
  - `NUM_REGS = 32`
  - typedef `wb_entry_t` (struct: `rd`, `data`)
- Sub-module `wb_fifo`:
  - Synchronous FIFO of `wb_entry_t`.
  - Parameter `DEPTH`.
  - Ports `push`/`pop`/`full`/`empty`/`head`.
  - Pointer wrap with an extra MSB.
  - Reset empties it.
- Arbitration mux, output register and scoreboard live in `wb_arbiter`.

## Test plan
- Reset, then `alu_valid=1`, `alu_rd=5`, `alu_data=0xDEADBEEF` in cycle 1 → cycle 2 shows `rf_write_enable=1`, `rf_rdi=5`, `rf_rd=0xDEADBEEF`. `alu_rd=0` → `rf_write_enable=0`.
- `issue_rd=7`, then 3 cycles later `md_valid` with `md_rd=7`, `md_data=0x12345678`, no ALU traffic:
  - `busy[7]=1` from issue+1 until the write cycle.
  - Bypass write one cycle after acceptance, with `busy[7]=0` in that same cycle.
- ALU valid 4 consecutive cycles while MUL/DIV offers rd=3, 4, 9 back-to-back:
  - First two are accepted; `md_ready=0` after the FIFO fills.
  - Writes appear in order ALU×4, then 3, 4, 9.
  - No result is lost or duplicated.
- Same edge `issue_valid` with `issue_rd=10` and MUL/DIV write-back of rd=10 → `busy[10]` remains 1.
- Assert `rst` while FIFO holds 2 entries and `busy=0x0000_0C00` → next cycle all outputs 0, `busy=0`, and no `rf_write_enable` pulse thereafter.
- Random ALU/MUL/DIV traffic against a reference-model register array:
  - Final contents match.
  - `busy` equals outstanding issues at every cycle.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared core-wide widths and the write-back entry type.
// No logic; constants and types only.
// Consumers import with rv_pkg::*.
package rv_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  // One pending register-file write: destination index plus result.
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of ALU/MUL-DIV/issue inputs and register-file/scoreboard outputs of the write-back arbiter.
// No logic; slave modport is the arbiter side, master modport is the driving side.
// md_valid/md_ready is the only stallable handshake; the ALU path has no backpressure.
interface wb_arbiter_if #(
  parameter int XLEN = rv_pkg::XLEN
) ();

  logic                               alu_valid;
  logic [rv_pkg::REG_IDX_W-1:0]       alu_rd;
  logic [XLEN-1:0]                    alu_data;

  logic                               md_valid;
  logic                               md_ready;
  logic [rv_pkg::REG_IDX_W-1:0]       md_rd;
  logic [XLEN-1:0]                    md_data;

  logic                               issue_valid;
  logic [rv_pkg::REG_IDX_W-1:0]       issue_rd;

  logic [rv_pkg::NUM_REGS-1:0]        busy;

  logic                               rf_write_enable;
  logic [rv_pkg::REG_IDX_W-1:0]       rf_rdi;
  logic [XLEN-1:0]                    rf_rd;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  md_valid, md_rd, md_data,
    input  issue_valid, issue_rd,
    output md_ready, busy,
    output rf_write_enable, rf_rdi, rf_rd
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output md_valid, md_rd, md_data,
    output issue_valid, issue_rd,
    input  md_ready, busy,
    input  rf_write_enable, rf_rdi, rf_rd
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of wb_entry_t used to park MUL/DIV results while the write port is busy.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: caller must respect full; a push on full is only taken when a pop happens on the same edge.
module wb_fifo import rv_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_dat,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  // AW is at least 1 so a depth-1 FIFO still has a real index bit; the
  // occupancy compare against DEPTH keeps capacity exact.
  localparam int             AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int             SLOTS     = 1 << AW;
  localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);

  wb_entry_t   mem_q [SLOTS];
  wb_entry_t   mem_d [SLOTS];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = ((wr_ptr_q - rd_ptr_q) == DEPTH_CNT);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next pointer values and storage write.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: it is only read when non-empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and MUL/DIV results onto the single register-file write port and tracks outstanding MUL/DIV destinations.
// Latency: 1 cycle for ALU and bypassed MUL/DIV; buffered MUL/DIV waits for ALU-free cycles in FIFO order.
// Backpressure: md_ready drops only when the FIFO is full (or in reset); ALU results are never stalled.
module wb_arbiter #(
  parameter int XLEN       = rv_pkg::XLEN,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter_if.slave   bus
);

  import rv_pkg::*;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  wb_entry_t             fifo_head;
  wb_entry_t             md_entry;
  logic                  md_ready;
  logic                  md_fire;

  logic                  rf_write_enable_q, rf_write_enable_d;
  logic [REG_IDX_W-1:0]  rf_rdi_q, rf_rdi_d;
  logic [XLEN-1:0]       rf_rd_q, rf_rd_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  logic                  clr_vld;
  logic [REG_IDX_W-1:0]  clr_idx;

  // Ready depends only on FIFO state so a producer can never see it toggle
  // with its own valid or with ALU traffic.
  assign md_ready      = !rst && !fifo_full;
  assign md_fire       = bus.md_valid && md_ready;
  assign md_entry.rd   = bus.md_rd;
  assign md_entry.data = bus.md_data;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (md_entry),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  // Source select: ALU first, then oldest buffered MUL/DIV, then direct bypass.
  always_comb begin
    rf_write_enable_d = 1'b0;
    rf_rdi_d          = rf_rdi_q;
    rf_rd_d           = rf_rd_q;
    fifo_push         = 1'b0;
    fifo_pop          = 1'b0;
    clr_vld           = 1'b0;
    clr_idx           = '0;
    if (bus.alu_valid) begin
      rf_write_enable_d = (bus.alu_rd != '0);
      rf_rdi_d          = bus.alu_rd;
      rf_rd_d           = bus.alu_data;
      fifo_push         = md_fire;
    end else if (!fifo_empty) begin
      rf_write_enable_d = (fifo_head.rd != '0);
      rf_rdi_d          = fifo_head.rd;
      rf_rd_d           = fifo_head.data;
      fifo_pop          = 1'b1;
      fifo_push         = md_fire;
      clr_vld           = 1'b1;
      clr_idx           = fifo_head.rd;
    end else if (md_fire) begin
      rf_write_enable_d = (md_entry.rd != '0);
      rf_rdi_d          = md_entry.rd;
      rf_rd_d           = md_entry.data;
      clr_vld           = 1'b1;
      clr_idx           = md_entry.rd;
    end
  end

  // Scoreboard update: clear on MUL/DIV write-back, then set on issue so a
  // same-edge set on the same index wins; x0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_vld) begin
      busy_d[clr_idx] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != '0)) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Output register and scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write_enable_q <= 1'b0;
      rf_rdi_q          <= '0;
      rf_rd_q           <= '0;
      busy_q            <= '0;
    end else begin
      rf_write_enable_q <= rf_write_enable_d;
      rf_rdi_q          <= rf_rdi_d;
      rf_rd_q           <= rf_rd_d;
      busy_q            <= busy_d;
    end
  end

  assign bus.md_ready        = md_ready;
  assign bus.busy            = busy_q;
  assign bus.rf_write_enable = rf_write_enable_q;
  assign bus.rf_rdi          = rf_rdi_q;
  assign bus.rf_rd           = rf_rd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and random bench for wb_arbiter against a queue-based reference model.
// Model advances on each rising edge from the inputs present at that edge.
// Outputs are compared on the falling edge of every cycle.
module tb_wb_arbiter;

  import rv_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wb_arbiter_if #(.XLEN(XLEN)) bus ();

  wb_arbiter #(
    .XLEN       (XLEN),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  wb_entry_t   mq[$];
  logic        exp_wen;
  logic [4:0]  exp_rdi;
  logic [31:0] exp_rd;
  logic [31:0] exp_busy;
  logic [31:0] ref_regs [32];
  logic [31:0] dut_regs [32];
  logic        last_fire;
  logic [31:0] inflight;

  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total    = 0;
  int          wr_log[$];
  logic [4:0]  pend[$];
  int          md_ids[3];
  int          exp_order[7];
  int          k;
  int          guard;
  logic [4:0]  r;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural write-back rules applied at one rising edge.
  task automatic model_edge();
    wb_entry_t e;
    wb_entry_t sel;
    logic      fire;
    logic      have;
    logic      is_md;
    fire      = bus.md_valid && !rst && (mq.size() < DEPTH);
    last_fire = fire;
    if (rst) begin
      mq.delete();
      exp_wen  = 1'b0;
      exp_rdi  = '0;
      exp_rd   = '0;
      exp_busy = '0;
      inflight = '0;
      return;
    end
    e.rd   = bus.md_rd;
    e.data = bus.md_data;
    have   = 1'b0;
    is_md  = 1'b0;
    sel    = '0;
    if (bus.alu_valid) begin
      sel.rd   = bus.alu_rd;
      sel.data = bus.alu_data;
      have     = 1'b1;
      if (fire) mq.push_back(e);
    end else if (mq.size() > 0) begin
      sel   = mq.pop_front();
      have  = 1'b1;
      is_md = 1'b1;
      if (fire) mq.push_back(e);
    end else if (fire) begin
      sel   = e;
      have  = 1'b1;
      is_md = 1'b1;
    end
    if (have) begin
      exp_rdi = sel.rd;
      exp_rd  = sel.data;
      exp_wen = (sel.rd != 0);
      if (exp_wen) ref_regs[sel.rd] = sel.data;
      if (is_md) begin
        exp_busy[sel.rd] = 1'b0;
        inflight[sel.rd] = 1'b0;
      end
    end else begin
      exp_wen = 1'b0;
    end
    if (bus.issue_valid && bus.issue_rd != 0) exp_busy[bus.issue_rd] = 1'b1;
    exp_busy[0] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("cyc_wen",   bus.rf_write_enable, exp_wen);
    check("cyc_rdi",   bus.rf_rdi, exp_rdi);
    check("cyc_rd",    bus.rf_rd, exp_rd);
    check("cyc_busy",  bus.busy, exp_busy);
    check("cyc_ready", bus.md_ready, (!rst && mq.size() < DEPTH));
    if (bus.rf_write_enable) begin
      dut_regs[bus.rf_rdi] = bus.rf_rd;
      wr_log.push_back(int'(bus.rf_rdi));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ref_regs[i] = '0;
      dut_regs[i] = '0;
    end
    inflight        = '0;
    last_fire       = 1'b0;
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.md_valid    = 1'b0;
    bus.md_rd       = '0;
    bus.md_data     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = '0;

    // Reset state
    tick();
    tick();
    check("rst_wen",   bus.rf_write_enable, 0);
    check("rst_rdi",   bus.rf_rdi, 0);
    check("rst_rd",    bus.rf_rd, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_ready", bus.md_ready, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", bus.md_ready, 1);

    // ALU write and write to x0
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    check("alu_wen", bus.rf_write_enable, 1);
    check("alu_rdi", bus.rf_rdi, 5);
    check("alu_rd",  bus.rf_rd, 32'hDEADBEEF);
    bus.alu_rd = 5'd0; bus.alu_data = 32'h1;
    tick();
    check("alu_x0_wen", bus.rf_write_enable, 0);
    bus.alu_valid = 1'b0;
    tick();
    check("idle_wen", bus.rf_write_enable, 0);

    // Issue x7, result bypassed three cycles later
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    tick();
    bus.issue_valid = 1'b0;
    check("busy7_n1", bus.busy[7], 1);
    tick();
    check("busy7_n2", bus.busy[7], 1);
    tick();
    check("busy7_n3", bus.busy[7], 1);
    bus.md_valid = 1'b1; bus.md_rd = 5'd7; bus.md_data = 32'h12345678;
    check("byp_ready", bus.md_ready, 1);
    tick();
    bus.md_valid = 1'b0;
    check("byp_wen",   bus.rf_write_enable, 1);
    check("byp_rdi",   bus.rf_rdi, 7);
    check("byp_rd",    bus.rf_rd, 32'h12345678);
    check("byp_busy7", bus.busy[7], 0);

    // ALU burst of 4 while MUL/DIV offers 3, 4, 9
    md_ids = '{3, 4, 9};
    for (int i = 0; i < 3; i++) begin
      bus.issue_valid = 1'b1; bus.issue_rd = 5'(md_ids[i]);
      tick();
    end
    bus.issue_valid = 1'b0;
    check("burst_busy", bus.busy, 32'h0000_0218);
    wr_log.delete();
    k = 0;
    for (int c = 0; c < 9; c++) begin
      bus.alu_valid = (c < 4);
      bus.alu_rd    = 5'(20 + c);
      bus.alu_data  = 32'hA000_0000 + 32'(c);
      bus.md_valid  = (k < 3);
      if (k < 3) begin
        bus.md_rd   = 5'(md_ids[k]);
        bus.md_data = 32'hB000_0000 + 32'(k);
      end
      if (c < 4) check("burst_ready", bus.md_ready, (c < 2));
      tick();
      if (last_fire) k++;
    end
    bus.alu_valid = 1'b0;
    bus.md_valid  = 1'b0;
    check("burst_accepted", k, 3);
    exp_order = '{20, 21, 22, 23, 3, 4, 9};
    check("burst_nwrites", wr_log.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < wr_log.size()) check("burst_order", wr_log[i], exp_order[i]);
    end
    check("burst_busy_clr", bus.busy, 0);

    // Same-edge issue and write-back of x10: set wins
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd10;
    tick();
    bus.md_valid = 1'b1; bus.md_rd = 5'd10; bus.md_data = 32'h0A0A0A0A;
    tick();
    bus.md_valid = 1'b0;
    bus.issue_valid = 1'b0;
    check("same_wen",    bus.rf_write_enable, 1);
    check("same_rdi",    bus.rf_rdi, 10);
    check("same_busy10", bus.busy[10], 1);

    // Fill FIFO with two entries then reset
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd11;
    tick();
    bus.issue_valid = 1'b0;
    check("pre_busy", bus.busy, 32'h0000_0C00);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h1111;
    bus.md_valid = 1'b1; bus.md_rd = 5'd10; bus.md_data = 32'hC0C0;
    tick();
    bus.md_rd = 5'd11; bus.md_data = 32'hC1C1;
    tick();
    bus.alu_valid = 1'b0;
    bus.md_valid  = 1'b0;
    check("full_ready", bus.md_ready, 0);
    check("full_busy",  bus.busy, 32'h0000_0C00);
    rst = 1'b1;
    tick();
    check("mid_rst_wen",   bus.rf_write_enable, 0);
    check("mid_rst_rdi",   bus.rf_rdi, 0);
    check("mid_rst_rd",    bus.rf_rd, 0);
    check("mid_rst_busy",  bus.busy, 0);
    check("mid_rst_ready", bus.md_ready, 0);
    rst = 1'b0;
    wr_log.delete();
    repeat (4) tick();
    check("post_rst_writes", wr_log.size(), 0);
    check("post_rst_ready2", bus.md_ready, 1);

    // Random traffic
    pend.delete();
    for (int c = 0; c < 600; c++) begin
      bus.alu_valid = ($urandom_range(0, 99) < 45);
      bus.alu_rd    = 5'($urandom_range(0, 31));
      bus.alu_data  = $urandom;
      if (!bus.md_valid && pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        bus.md_valid = 1'b1;
        bus.md_rd    = pend.pop_front();
        bus.md_data  = $urandom;
      end
      bus.issue_valid = 1'b0;
      if ($urandom_range(0, 99) < 30) begin
        r = 5'($urandom_range(0, 31));
        if (r == 0 || !inflight[r]) begin
          bus.issue_valid = 1'b1;
          bus.issue_rd    = r;
          pend.push_back(r);
          if (r != 0) inflight[r] = 1'b1;
        end
      end
      tick();
      if (last_fire) bus.md_valid = 1'b0;
    end

    // Drain all outstanding MUL/DIV work
    bus.alu_valid   = 1'b0;
    bus.issue_valid = 1'b0;
    guard = 0;
    while ((pend.size() > 0 || bus.md_valid || mq.size() > 0) && guard < 200) begin
      if (!bus.md_valid && pend.size() > 0) begin
        bus.md_valid = 1'b1;
        bus.md_rd    = pend.pop_front();
        bus.md_data  = $urandom;
      end
      tick();
      if (last_fire) bus.md_valid = 1'b0;
      guard++;
    end
    check("drain_done", (guard < 200), 1);
    check("final_busy", bus.busy, 0);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("regfile_x%0d", i), dut_regs[i], ref_regs[i]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
